// File: rtl/core_clk_ctrl.sv
// rtl/core_clk_ctrl.sv - programmable core clock-enable generator with HALT/RUN/STEP control
// Optional step counter built only when CORE_STEP_CNT_EN is defined.
module core_clk_ctrl #(
   parameter int DIV_W     = 8,
   parameter int DIV_RESET = 1,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             _reset,
   input  logic [DIV_W-1:0] div,
   input  logic             div_load,
   input  logic             run,
   input  logic             halt_req,
   input  logic             step_req,
   output logic             core_en,
   output logic             phase,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] step_cnt
);

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q;
   logic             tick;

   assign tick  = (state_q != ST_HALT) && (cnt_q == div_q) && !div_load;
   assign state = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HALT: begin
            if (halt_req)      state_d = ST_HALT;
            else if (step_req) state_d = ST_STEP;
            else if (run)      state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_req || !run) state_d = ST_HALT;
         end
         ST_STEP: begin
            if (halt_req || tick) state_d = ST_HALT;
         end
         default: state_d = ST_HALT;
      endcase
   end

   // cnt sits at 0 whenever halted, so entering RUN/STEP always starts a fresh period.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (div_load || tick || state_q == ST_HALT || state_d == ST_HALT)
         cnt_d = '0;
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q <= ST_HALT;
         cnt_q   <= '0;
         div_q   <= DIV_W'(DIV_RESET);
         core_en <= 1'b0;
         phase   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         core_en <= tick;
         if (div_load) div_q <= div;
         if (tick)     phase <= ~phase;
      end
   end

`ifdef CORE_STEP_CNT_EN
   logic [CNT_W-1:0] step_cnt_q;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset)   step_cnt_q <= '0;
      else if (tick) step_cnt_q <= step_cnt_q + 1'b1;
   end

   assign step_cnt = step_cnt_q;
`else
   assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_core_clk_ctrl.sv
// tb/tb_core_clk_ctrl.sv - directed self-checking bench for core_clk_ctrl
// Expects step_cnt=44 after 300 enables when CORE_STEP_CNT_EN is defined, else 0.
module tb_core_clk_ctrl;

   localparam int DIV_W = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             _reset = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic             div_load = 1'b0;
   logic             run = 1'b0;
   logic             halt_req = 1'b0;
   logic             step_req = 1'b0;
   logic             core_en;
   logic             phase;
   logic [1:0]       state;
   logic [CNT_W-1:0] step_cnt;

   int checks = 0;
   int failures = 0;

   core_clk_ctrl #(.DIV_W(DIV_W), .DIV_RESET(1), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      ._reset   (_reset),
      .div      (div),
      .div_load (div_load),
      .run      (run),
      .halt_req (halt_req),
      .step_req (step_req),
      .core_en  (core_en),
      .phase    (phase),
      .state    (state),
      .step_cnt (step_cnt)
   );

   always #5 clk = ~clk;

   task automatic edge_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      logic bad;
      logic [31:0] exp_cnt;

      // reset state
      #12;
      chk("rst_state", state, 0);
      chk("rst_en", core_en, 0);
      chk("rst_phase", phase, 0);
      chk("rst_cnt", step_cnt, 0);
      @(negedge clk);
      _reset = 1'b1;

      // 1) run with default div_q=1
      run = 1'b1;
      edge_step();
      chk("t1_state_run", state, 1);
      chk("t1_en_e0", core_en, 0);
      for (int i = 1; i <= 6; i++) begin
         edge_step();
         chk($sformatf("t1_en_e%0d", i), core_en, (i % 2 == 0) ? 1 : 0);
         if (i % 2 == 0) chk($sformatf("t1_phase_e%0d", i), phase, (i % 4 == 2) ? 1 : 0);
      end
      edge_step();
      chk("t1_en_e7", core_en, 0);

      // 2) load div=0 on a would-be tick edge
      div = 8'd0;
      div_load = 1'b1;
      edge_step();
      chk("t2_suppressed", core_en, 0);
      chk("t2_phase_hold", phase, 1);
      div_load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         edge_step();
         chk($sformatf("t2_en_%0d", i), core_en, 1);
      end
      chk("t2_phase", phase, 0);

      // 3) drop run (coincident tick survives), load div=3, single step
      run = 1'b0;
      edge_step();
      chk("t3_halt", state, 0);
      chk("t3_tick_kept", core_en, 1);
      div = 8'd3;
      div_load = 1'b1;
      edge_step();
      chk("t3_load_en", core_en, 0);
      div_load = 1'b0;
      step_req = 1'b1;
      edge_step();
      step_req = 1'b0;
      chk("t3_step_state", state, 2);
      for (int i = 1; i <= 3; i++) begin
         edge_step();
         chk($sformatf("t3_wait_en%0d", i), core_en, 0);
      end
      chk("t3_wait_state", state, 2);
      edge_step();
      chk("t3_step_en", core_en, 1);
      chk("t3_step_done", state, 0);
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         edge_step();
         if (core_en !== 1'b0) bad = 1'b1;
      end
      chk("t3_no_more", bad, 0);

      // 4) halt_req beats step_req in HALT
      halt_req = 1'b1;
      step_req = 1'b1;
      edge_step();
      halt_req = 1'b0;
      step_req = 1'b0;
      chk("t4_state", state, 0);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         edge_step();
         if (core_en !== 1'b0 || state !== 2'd0) bad = 1'b1;
      end
      chk("t4_quiet", bad, 0);

      // maximal divisor: period 256
      div = 8'd255;
      div_load = 1'b1;
      edge_step();
      div_load = 1'b0;
      run = 1'b1;
      edge_step();
      n = 0;
      while (core_en !== 1'b1 && n < 300) begin
         edge_step();
         n++;
      end
      chk("max_period", n, 256);
      run = 1'b0;
      edge_step();
      chk("max_halt", state, 0);

      // 5) async reset mid-run with div_q=5, cnt=3
      div = 8'd5;
      div_load = 1'b1;
      edge_step();
      div_load = 1'b0;
      run = 1'b1;
      for (int i = 0; i < 4; i++) edge_step();
      chk("t5_pre_state", state, 1);
      chk("t5_pre_phase", phase, 1);
      #2 _reset = 1'b0;
      #1;
      chk("t5_state", state, 0);
      chk("t5_en", core_en, 0);
      chk("t5_phase", phase, 0);
      chk("t5_cnt", step_cnt, 0);
      @(negedge clk);
      _reset = 1'b1;
      edge_step();
      chk("t5_rerun", state, 1);
      edge_step();
      chk("t5_div_e1", core_en, 0);
      edge_step();
      chk("t5_div_e2", core_en, 1);

      // 6) 300 enables at div_q=0 from a clean reset
      run = 1'b0;
      _reset = 1'b0;
      #1;
      _reset = 1'b1;
      div = 8'd0;
      div_load = 1'b1;
      edge_step();
      div_load = 1'b0;
      run = 1'b1;
      edge_step();
      for (int i = 0; i < 300; i++) edge_step();
`ifdef CORE_STEP_CNT_EN
      exp_cnt = 32'd44;
`else
      exp_cnt = 32'd0;
`endif
      chk("t6_en", core_en, 1);
      chk("t6_step_cnt", step_cnt, exp_cnt);
      run = 1'b0;
      edge_step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
